// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce_multi
// Brief   : Multi-channel push-button conditioner: shared sample tick, N-sample
//           debounce, press/release pulses and hold-to-repeat pulses.
// Revision: 1.0 - initial release
// ============================================================================
module key_debounce_multi #(
    parameter int CH         = 4,
    parameter int DIV        = 250000,
    parameter int STABLE     = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int HOLD_TICKS = 40,
    parameter int RPT_TICKS  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CH-1:0] bin,
    output logic [CH-1:0] level,
    output logic [CH-1:0] press,
    // release/repeat are reserved words, hence the key_ prefix
    output logic [CH-1:0] key_release,
    output logic [CH-1:0] key_repeat,
    output logic          tick
);

    localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW   = $clog2(STABLE + 1);
    localparam int HMAX = (HOLD_TICKS > RPT_TICKS) ? HOLD_TICKS : RPT_TICKS;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] c_div_last  = DW'(DIV - 1);
    localparam logic [CW-1:0] c_stable    = CW'(STABLE);
    localparam logic [HW-1:0] c_hold      = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] c_rpt       = HW'(RPT_TICKS);
    localparam logic [CH-1:0] c_idle_pins = (ACTIVE_LOW != 0) ? {CH{1'b1}} : {CH{1'b0}};

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_hold = 2'd1;
    localparam logic [1:0] c_st_rpt  = 2'd2;

    logic [DW-1:0] r_div;
    logic [CH-1:0] r_sync1;
    logic [CH-1:0] r_sync2;
    logic [CH-1:0] w_s;
    logic          w_tick;

    assign w_tick = (r_div == c_div_last) && en;
    assign tick   = w_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= r_div + DW'(1);
        end
    end

    // Synchronizer keeps running while en=0 so resuming sees a settled pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= c_idle_pins;
            r_sync2 <= c_idle_pins;
        end else begin
            r_sync1 <= bin;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic          r_level;
        logic [CW-1:0] r_cnt;
        logic [HW-1:0] r_hcnt;
        logic [1:0]    r_state;
        logic          r_press;
        logic          r_release;
        logic          r_repeat;
        logic [CW-1:0] w_cnt_nxt;
        logic [HW-1:0] w_hcnt_nxt;
        logic          w_flip;

        assign w_cnt_nxt  = r_cnt + CW'(1);
        assign w_hcnt_nxt = r_hcnt + HW'(1);
        assign w_flip     = (w_s[i] != r_level) && (w_cnt_nxt == c_stable);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_level   <= 1'b0;
                r_cnt     <= '0;
                r_hcnt    <= '0;
                r_state   <= c_st_idle;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;
                if (w_tick) begin
                    if (w_s[i] != r_level) begin
                        if (w_flip) begin
                            r_level   <= w_s[i];
                            r_cnt     <= '0;
                            r_press   <= w_s[i];
                            r_release <= ~w_s[i];
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end else begin
                        r_cnt <= '0;
                    end

                    // In IDLE a flip can only be a press; in HOLD/RPT only a release.
                    case (r_state)
                        c_st_idle: begin
                            if (w_flip) begin
                                r_state <= c_st_hold;
                                r_hcnt  <= '0;
                            end
                        end
                        c_st_hold: begin
                            if (w_flip) begin
                                r_state <= c_st_idle;
                            end else if (w_hcnt_nxt == c_hold) begin
                                r_repeat <= 1'b1;
                                r_state  <= c_st_rpt;
                                r_hcnt   <= '0;
                            end else begin
                                r_hcnt <= w_hcnt_nxt;
                            end
                        end
                        c_st_rpt: begin
                            if (w_flip) begin
                                r_state <= c_st_idle;
                            end else if (w_hcnt_nxt == c_rpt) begin
                                r_repeat <= 1'b1;
                                r_hcnt   <= '0;
                            end else begin
                                r_hcnt <= w_hcnt_nxt;
                            end
                        end
                        default: begin
                            r_state <= c_st_idle;
                        end
                    endcase
                end
            end
        end

        assign level[i]       = r_level;
        assign press[i]       = r_press & en;
        assign key_release[i] = r_release & en;
        assign key_repeat[i]  = r_repeat & en;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_debounce_multi
// Brief   : Directed bench for key_debounce_multi with a cycle-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_key_debounce_multi;

    localparam int CH     = 4;
    localparam int DIV    = 4;
    localparam int STABLE = 3;
    localparam int HOLD   = 5;
    localparam int RPT    = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b1;
    logic [CH-1:0] bin   = 4'b0000;
    logic [CH-1:0] level, press, key_release, key_repeat;
    logic          tick;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk      = 1'b0;

    key_debounce_multi #(
        .CH(CH), .DIV(DIV), .STABLE(STABLE), .ACTIVE_LOW(1),
        .HOLD_TICKS(HOLD), .RPT_TICKS(RPT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bin(bin),
        .level(level), .press(press), .key_release(key_release),
        .key_repeat(key_repeat), .tick(tick)
    );

    always #5 clk = ~clk;

    // Reference model: pins delayed two clocks, debounced by run length, repeat by ticks since press.
    logic [CH-1:0] m_sync1 = 4'b1111, m_sync2 = 4'b1111;
    logic [CH-1:0] m_level = '0, m_press = '0, m_rel = '0, m_rep = '0;
    int m_div = 0;
    int m_run [CH];
    int m_held[CH];
    bit m_holding[CH];

    always @(posedge clk) begin
        bit t;
        logic s;
        if (!rst_n) begin
            m_sync1 = 4'b1111; m_sync2 = 4'b1111; m_div = 0;
            m_level = '0; m_press = '0; m_rel = '0; m_rep = '0;
            for (int i = 0; i < CH; i++) begin
                m_run[i] = 0; m_held[i] = 0; m_holding[i] = 1'b0;
            end
        end else begin
            t = (m_div == DIV - 1) && en;
            m_press = '0; m_rel = '0; m_rep = '0;
            if (t) begin
                for (int i = 0; i < CH; i++) begin
                    s = ~m_sync2[i];
                    if (s != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == STABLE) begin
                            m_level[i] = s;
                            m_run[i]   = 0;
                            if (s) begin
                                m_press[i] = 1'b1; m_holding[i] = 1'b1; m_held[i] = 0;
                            end else begin
                                m_rel[i] = 1'b1; m_holding[i] = 1'b0;
                            end
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    if (m_holding[i] && !m_press[i]) begin
                        m_held[i]++;
                        if (m_held[i] == HOLD || (m_held[i] > HOLD && (m_held[i] - HOLD) % RPT == 0))
                            m_rep[i] = 1'b1;
                    end
                end
            end
            if (t) m_div = 0;
            else if (en) m_div++;
            m_sync2 = m_sync1;
            m_sync1 = bin;
        end
    end

    always @(negedge clk) begin
        logic [4*CH:0] exp_v, got_v;
        if (chk) begin
            exp_v = {m_level, m_press & {CH{en}}, m_rel & {CH{en}}, m_rep & {CH{en}},
                     (m_div == DIV - 1) && en};
            got_v = {level, press, key_release, key_repeat, tick};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_compare t=%0t got lvl/prs/rel/rep/tick=%b required=%b",
                         $time, got_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Wait until n tick strobes have been seen, then move just past the sampling edge.
    task automatic wait_ticks(input int n);
        int seen = 0;
        for (int c = 0; c < 40 * n && seen < n; c++) begin
            @(negedge clk);
            if (tick) seen++;
        end
        if (seen < n) check("wait_ticks_timeout", 32'(seen), 32'(n));
        step();
    endtask

    function automatic logic [CH-1:0] sel(input int kind);
        case (kind)
            0:       return press;
            1:       return key_release;
            default: return key_repeat;
        endcase
    endfunction

    task automatic ticks_until(input string name, input int kind, input logic [CH-1:0] mask,
                               output int nt, output logic [CH-1:0] v);
        bit found = 1'b0;
        nt = 0;
        v  = '0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if ((sel(kind) & mask) != '0) begin
                found = 1'b1;
                v     = sel(kind);
            end else if (tick) begin
                nt++;
            end
        end
        if (!found) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
            nt = -1;
        end
    endtask

    task automatic watch(input int n, output int nt, output logic [CH-1:0] op,
                         output logic [CH-1:0] orl, output logic [CH-1:0] orp);
        nt = 0; op = '0; orl = '0; orp = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (tick) nt++;
            op  |= press;
            orl |= key_release;
            orp |= key_repeat;
        end
    endtask

    initial begin
        int nt, gap;
        logic [CH-1:0] v, op, orl, orp;

        // Reset with all pins low, then release to idle.
        @(posedge clk);
        chk = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_press", 32'(press), 32'd0);
        check("rst_release", 32'(key_release), 32'd0);
        check("rst_repeat", 32'(key_repeat), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        step();
        rst_n = 1'b1;
        bin   = 4'b1111;

        wait_ticks(1);
        gap = 0;
        for (int c = 1; c <= 20 && gap == 0; c++) begin
            @(negedge clk);
            if (tick) gap = c;
        end
        check("tick_period", 32'(gap), 32'd4);

        // Clean press and release on channel 0.
        wait_ticks(1);
        bin[0] = 1'b0;
        ticks_until("press0", 0, 4'b0001, nt, v);
        check("press0_ticks", 32'(nt), 32'd3);
        check("press0_vec", 32'(v), 32'b0001);
        check("press0_level", 32'(level), 32'b0001);
        wait_ticks(1);
        bin[0] = 1'b1;
        ticks_until("release0", 1, 4'b0001, nt, v);
        check("release0_ticks", 32'(nt), 32'd3);
        check("release0_level", 32'(level), 32'd0);

        // Two-sample glitch on channel 1 is rejected and leaves the run count at zero.
        wait_ticks(1);
        bin[1] = 1'b0;
        wait_ticks(2);
        bin[1] = 1'b1;
        watch(24, nt, op, orl, orp);
        check("glitch_press", 32'(op[1]), 32'd0);
        check("glitch_level", 32'(level[1]), 32'd0);
        wait_ticks(1);
        bin[1] = 1'b0;
        ticks_until("press1", 0, 4'b0010, nt, v);
        check("press1_full_ticks", 32'(nt), 32'd3);
        wait_ticks(1);
        bin[1] = 1'b1;
        ticks_until("release1", 1, 4'b0010, nt, v);
        check("release1_ticks", 32'(nt), 32'd3);

        // Auto-repeat on channel 2: first at 5 ticks, then every 2; restarts after release.
        wait_ticks(1);
        bin[2] = 1'b0;
        ticks_until("press2", 0, 4'b0100, nt, v);
        check("press2_ticks", 32'(nt), 32'd3);
        ticks_until("rpt_first", 2, 4'b0100, nt, v);
        check("rpt_first_ticks", 32'(nt), 32'd5);
        ticks_until("rpt_second", 2, 4'b0100, nt, v);
        check("rpt_second_ticks", 32'(nt), 32'd2);
        ticks_until("rpt_third", 2, 4'b0100, nt, v);
        check("rpt_third_ticks", 32'(nt), 32'd2);
        wait_ticks(1);
        bin[2] = 1'b1;
        ticks_until("release2", 1, 4'b0100, nt, v);
        check("release2_ticks", 32'(nt), 32'd3);
        wait_ticks(1);
        bin[2] = 1'b0;
        ticks_until("press2b", 0, 4'b0100, nt, v);
        ticks_until("rpt_restart", 2, 4'b0100, nt, v);
        check("rpt_restart_ticks", 32'(nt), 32'd5);
        wait_ticks(1);
        bin[2] = 1'b1;
        ticks_until("release2b", 1, 4'b0100, nt, v);

        // All channels at once.
        wait_ticks(1);
        bin = 4'b0000;
        ticks_until("press_all", 0, 4'b1111, nt, v);
        check("press_all_vec", 32'(v), 32'b1111);
        check("press_all_ticks", 32'(nt), 32'd3);
        wait_ticks(1);
        bin = 4'b1111;
        ticks_until("release_all", 1, 4'b1111, nt, v);
        check("release_all_vec", 32'(v), 32'b1111);

        // en=0 mid-debounce freezes the divider and run count.
        wait_ticks(1);
        bin[3] = 1'b0;
        wait_ticks(1);
        en = 1'b0;
        watch(20, nt, op, orl, orp);
        check("en_off_ticks", 32'(nt), 32'd0);
        check("en_off_pulses", 32'(op | orl | orp), 32'd0);
        step();
        en = 1'b1;
        ticks_until("press3_resume", 0, 4'b1000, nt, v);
        check("press3_resume_ticks", 32'(nt), 32'd2);

        // Reset while held: level drops with no release pulse.
        step();
        rst_n = 1'b0;
        watch(3, nt, op, orl, orp);
        check("rst_hold_release", 32'(orl), 32'd0);
        check("rst_hold_level", 32'(level), 32'd0);
        step();
        rst_n = 1'b1;
        bin   = 4'b1111;
        watch(40, nt, op, orl, orp);
        check("post_rst_release", 32'(orl), 32'd0);
        check("post_rst_press", 32'(op), 32'd0);

        chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
